// File: rtl/elastic_fifo_flex_pkg.sv
// Shared definitions for the elastic FIFO family: safe pointer width and transfer encoding.
package elastic_fifo_flex_pkg;

  // Width of an index into n slots; never zero, so a single-slot buffer still gets a 1-bit pointer.
  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef enum logic [1:0] {
    XferNone = 2'b00,
    XferRd   = 2'b01,
    XferWr   = 2'b10,
    XferBoth = 2'b11
  } xfer_e;

endpackage

// File: rtl/elastic_fifo_ptr.sv
// Wrap-around slot pointer; wraps explicitly at NUM_SLOTS-1 so non-power-of-two depths work.
module elastic_fifo_ptr
  import elastic_fifo_flex_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 2,
  parameter int unsigned PW        = safe_clog2(NUM_SLOTS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  localparam logic [PW-1:0] LastSlot = PW'(NUM_SLOTS - 1);

  logic [PW-1:0] ptr_d, ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (inc) begin
      ptr_d = (ptr_q == LastSlot) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/elastic_fifo_flex.sv
// Elastic valid/ready FIFO of any depth with optional fall-through bypass and occupancy outputs.
module elastic_fifo_flex
  import elastic_fifo_flex_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 2,
  parameter int unsigned DATA_TYPE = 32,
  parameter bit          BYPASS    = 1'b0,
  // NUM_SLOTS-1 would be illegal for a single slot, so that case falls back to 1.
  parameter int unsigned AF_THRESH = (NUM_SLOTS > 1) ? NUM_SLOTS - 1 : 1,
  parameter int unsigned CW        = $clog2(NUM_SLOTS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_TYPE-1:0] ins,
  input  logic                 ins_valid,
  output logic                 ins_ready,
  output logic [DATA_TYPE-1:0] outs,
  output logic                 outs_valid,
  input  logic                 outs_ready,
  output logic [CW-1:0]        count,
  output logic                 almost_full
);

  localparam int unsigned   PW        = safe_clog2(NUM_SLOTS);
  localparam logic [CW-1:0] FullCount = CW'(NUM_SLOTS);
  localparam logic [CW-1:0] AfCount   = CW'(AF_THRESH);

  if (NUM_SLOTS == 0) begin : gen_bad_slots
    $error("elastic_fifo_flex: NUM_SLOTS must be at least 1");
  end
  if (AF_THRESH == 0 || AF_THRESH > NUM_SLOTS) begin : gen_bad_af
    $error("elastic_fifo_flex: AF_THRESH must lie in 1..NUM_SLOTS");
  end

  logic [DATA_TYPE-1:0] mem_q [NUM_SLOTS];
  logic [CW-1:0]        count_d, count_q;
  logic [PW-1:0]        head, tail;
  logic                 empty, full;
  logic                 fire_in, fire_out, pass, wr, rd;
  xfer_e                xfer;

  assign empty = (count_q == '0);
  assign full  = (count_q == FullCount);

  // Gating with rst keeps both handshakes quiet for the whole time reset is held.
  assign ins_ready  = rst & (~full | outs_ready);
  assign outs_valid = rst & (~empty | (BYPASS & ins_valid));
  assign outs       = (BYPASS && empty) ? ins : mem_q[head];

  assign fire_in  = ins_valid & ins_ready;
  assign fire_out = outs_valid & outs_ready;
  assign pass     = BYPASS & empty & fire_in & fire_out;
  assign wr       = fire_in & ~pass;
  assign rd       = fire_out & ~empty;
  assign xfer     = xfer_e'({wr, rd});

  always_comb begin
    count_d = count_q;
    case (xfer)
      XferWr:  count_d = count_q + 1'b1;
      XferRd:  count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Storage carries no reset; contents are only observable once counted in.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem_q[tail] <= ins;
    end
  end

  elastic_fifo_ptr #(
    .NUM_SLOTS (NUM_SLOTS),
    .PW        (PW)
  ) u_head (
    .clk (clk),
    .rst (rst),
    .inc (rd),
    .ptr (head)
  );

  elastic_fifo_ptr #(
    .NUM_SLOTS (NUM_SLOTS),
    .PW        (PW)
  ) u_tail (
    .clk (clk),
    .rst (rst),
    .inc (wr),
    .ptr (tail)
  );

  assign count       = count_q;
  assign almost_full = (count_q >= AfCount);

endmodule

// File: tb/tb_elastic_fifo_flex.sv
// Directed bench: registered (a) and bypass (b) 3-slot FIFOs on shared stimulus, plus a 1-slot bypass FIFO (c).
module tb_elastic_fifo_flex;

  logic       clk;
  logic       rst;
  logic [7:0] s_ins;
  logic       s_valid, s_oready;
  logic       a_ins_ready, a_outs_valid, a_af;
  logic [7:0] a_outs;
  logic [1:0] a_count;
  logic       b_ins_ready, b_outs_valid, b_af;
  logic [7:0] b_outs;
  logic [1:0] b_count;
  logic [7:0] c_ins, c_outs;
  logic       c_valid, c_oready, c_ins_ready, c_outs_valid, c_af;
  logic [0:0] c_count;

  int checks = 0;
  int errors = 0;

  elastic_fifo_flex #(
    .NUM_SLOTS (3), .DATA_TYPE (8), .BYPASS (1'b0), .AF_THRESH (2)
  ) u_a (
    .clk (clk), .rst (rst), .ins (s_ins), .ins_valid (s_valid), .ins_ready (a_ins_ready),
    .outs (a_outs), .outs_valid (a_outs_valid), .outs_ready (s_oready),
    .count (a_count), .almost_full (a_af)
  );

  elastic_fifo_flex #(
    .NUM_SLOTS (3), .DATA_TYPE (8), .BYPASS (1'b1), .AF_THRESH (2)
  ) u_b (
    .clk (clk), .rst (rst), .ins (s_ins), .ins_valid (s_valid), .ins_ready (b_ins_ready),
    .outs (b_outs), .outs_valid (b_outs_valid), .outs_ready (s_oready),
    .count (b_count), .almost_full (b_af)
  );

  elastic_fifo_flex #(
    .NUM_SLOTS (1), .DATA_TYPE (8), .BYPASS (1'b1), .AF_THRESH (1)
  ) u_c (
    .clk (clk), .rst (rst), .ins (c_ins), .ins_valid (c_valid), .ins_ready (c_ins_ready),
    .outs (c_outs), .outs_valid (c_outs_valid), .outs_ready (c_oready),
    .count (c_count), .almost_full (c_af)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent, got, mcnt;
    logic fin, fout;

    rst = 1'b0; s_ins = '0; s_valid = 1'b0; s_oready = 1'b0;
    c_ins = '0; c_valid = 1'b0; c_oready = 1'b0;
    #1;
    chk("rst_ins_ready", a_ins_ready, 0);
    chk("rst_outs_valid", a_outs_valid, 0);
    chk("rst_count", a_count, 0);
    chk("rst_af", a_af, 0);
    step();
    step();
    rst = 1'b1;
    #1;
    chk("rel_ins_ready", a_ins_ready, 1);

    // Hold two tokens, then reset between edges.
    s_valid = 1'b1; s_ins = 8'hAA;
    step();
    s_ins = 8'hBB;
    step();
    s_valid = 1'b0;
    chk("hold2_count", a_count, 2);
    #2 rst = 1'b0;
    #1;
    chk("midrst_count", a_count, 0);
    chk("midrst_outs_valid", a_outs_valid, 0);
    chk("midrst_ins_ready", a_ins_ready, 0);
    #1 rst = 1'b1;
    step();
    chk("postrst_ins_ready", a_ins_ready, 1);
    chk("postrst_count", a_count, 0);

    // Fill with consumer stalled.
    s_oready = 1'b0; s_valid = 1'b1; s_ins = 8'h11;
    step();
    chk("fill1_count", a_count, 1);
    chk("fill1_af", a_af, 0);
    chk("fill1_outs", a_outs, 8'h11);
    s_ins = 8'h22;
    step();
    chk("fill2_af", a_af, 1);
    s_ins = 8'h33;
    step();
    chk("fill3_count", a_count, 3);
    chk("fill3_ins_ready", a_ins_ready, 0);
    s_valid = 1'b0;
    step();
    chk("fill_hold_outs", a_outs, 8'h11);
    chk("fill_hold_count", a_count, 3);

    // Full with simultaneous read and write.
    s_oready = 1'b1; s_valid = 1'b1; s_ins = 8'h44;
    #1;
    chk("full_rw_ins_ready", a_ins_ready, 1);
    step();
    s_valid = 1'b0;
    chk("full_rw_count", a_count, 3);
    chk("drain_22", a_outs, 8'h22);
    step();
    chk("drain_33", a_outs, 8'h33);
    step();
    chk("drain_44", a_outs, 8'h44);
    chk("drain_count1", a_count, 1);
    step();
    chk("drain_empty_valid", a_outs_valid, 0);
    chk("drain_empty_count", a_count, 0);

    // Stream ten tokens through with a random consumer.
    sent = 0; got = 0; mcnt = 0;
    for (int cyc = 0; cyc < 300 && got < 10; cyc++) begin
      s_ins = 8'(sent);
      s_valid = (sent < 10);
      s_oready = 1'($urandom_range(0, 1));
      #1;
      fin = s_valid & a_ins_ready;
      fout = a_outs_valid & s_oready;
      if (fout) begin
        chk("wrap_data", a_outs, 32'(got));
        got++;
      end
      step();
      if (fin) sent++;
      mcnt = mcnt + int'(fin) - int'(fout);
      chk("wrap_count", a_count, 32'(mcnt));
      chk("wrap_le3", 32'(a_count <= 2'd3), 1);
    end
    chk("wrap_all_out", got, 10);
    s_valid = 1'b0; s_oready = 1'b0;

    #2 rst = 1'b0;
    #2 rst = 1'b1;
    step();

    // Bypass versus registered on identical stimulus.
    s_ins = 8'hA5; s_valid = 1'b1; s_oready = 1'b1;
    #1;
    chk("byp_outs_valid", b_outs_valid, 1);
    chk("byp_outs", b_outs, 8'hA5);
    chk("reg_outs_valid0", a_outs_valid, 0);
    step();
    s_valid = 1'b0;
    chk("byp_count", b_count, 0);
    chk("reg_count", a_count, 1);
    chk("reg_outs_valid1", a_outs_valid, 1);
    chk("reg_outs", a_outs, 8'hA5);
    #1;
    chk("byp_idle_valid", b_outs_valid, 0);
    step();
    chk("reg_drained", a_count, 0);

    // Bypass FIFO with stalled consumer stores the token.
    s_ins = 8'h5A; s_valid = 1'b1; s_oready = 1'b0;
    step();
    s_valid = 1'b0;
    chk("byp_stall_count", b_count, 1);
    chk("byp_stall_outs", b_outs, 8'h5A);
    chk("byp_stall_valid", b_outs_valid, 1);

    // Depth 1 with bypass: one token per cycle under continuous valid/ready.
    c_valid = 1'b1; c_oready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      c_ins = 8'h60 + 8'(i);
      #1;
      chk("d1_ins_ready", c_ins_ready, 1);
      chk("d1_outs", c_outs, 32'h60 + 32'(i));
      chk("d1_outs_valid", c_outs_valid, 1);
      step();
      chk("d1_count", c_count, 0);
    end

    // Depth 1 with alternating consumer stalls.
    sent = 0; got = 0; mcnt = 0;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      c_ins = 8'h70 + 8'(sent);
      c_valid = (sent < 6);
      c_oready = (cyc % 2) == 1;
      #1;
      fin = c_valid & c_ins_ready;
      fout = c_outs_valid & c_oready;
      if (fout) begin
        chk("d1_alt_data", c_outs, 32'h70 + 32'(got));
        got++;
      end
      step();
      if (fin) sent++;
      mcnt = mcnt + int'(fin) - int'(fout);
      chk("d1_alt_count", c_count, 32'(mcnt));
      if (mcnt == 1) chk("d1_alt_af", c_af, 1);
    end
    chk("d1_alt_all_out", got, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
